// File: rtl/mem_arb_pkg.sv
// Shared types for the split I/D memory arbiter.
// Define MEM_ARB_RR_EN to make two-port conflicts round robin instead of B-over-A.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_A,
        SERVE_B
    } arb_state_t;

    typedef enum logic {
        GRANT_A,
        GRANT_B
    } grant_t;

    // Reads always move the full word.
    localparam logic [1:0] ByteEnAll = 2'b11;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between the fetch port (A) and the data port (B).
// MEM_ARB_RR_EN selects round robin on conflict; otherwise B has fixed priority.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   req_a,
    input  logic   req_b,
    input  grant_t last_grant,
    output logic   grant_valid,
    output grant_t grant
);

    grant_t conflict_grant;

`ifdef MEM_ARB_RR_EN
    assign conflict_grant = (last_grant == GRANT_B) ? GRANT_A : GRANT_B;
`else
    logic unused_last_grant;

    assign conflict_grant    = GRANT_B;
    assign unused_last_grant = (last_grant == GRANT_B);
`endif

    always_comb begin
        grant_valid = req_a | req_b;
        grant       = GRANT_A;
        if (req_a && req_b) begin
            grant = conflict_grant;
        end else if (req_b) begin
            grant = GRANT_B;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch (A) and data (B) requests onto a single physical memory port.
// Build option: MEM_ARB_RR_EN enables round-robin conflict resolution.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              mem_read_a,
    input  logic [ADDR_W-1:0] mem_address_a,
    output logic [DATA_W-1:0] mem_rdata_a,
    output logic              mem_resp_a,

    input  logic              mem_read_b,
    input  logic              mem_write_b,
    input  logic [ADDR_W-1:0] mem_address_b,
    input  logic [DATA_W-1:0] mem_wdata_b,
    input  logic [1:0]        mem_byte_en_b,
    output logic [DATA_W-1:0] mem_rdata_b,
    output logic              mem_resp_b,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [DATA_W-1:0] pmem_wdata,
    output logic [1:0]        pmem_byte_en,
    input  logic [DATA_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    arb_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        be_q, be_d;
    logic              write_q, write_d;

    logic   req_a;
    logic   req_b;
    logic   grant_valid;
    logic   take;
    grant_t grant;
    grant_t last_grant;

    assign req_a = mem_read_a;
    assign req_b = mem_read_b | mem_write_b;
    assign take  = (state_q == IDLE) && grant_valid;

    mem_arb_pick u_pick (
        .req_a       (req_a),
        .req_b       (req_b),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

`ifdef MEM_ARB_RR_EN
    grant_t last_grant_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q <= GRANT_A;
        end else if (take) begin
            last_grant_q <= grant;
        end
    end

    assign last_grant = last_grant_q;
`else
    assign last_grant = GRANT_A;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            write_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            write_q <= write_d;
        end
    end

    // The request is captured only at grant; port changes during service are ignored.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        write_d = write_q;
        unique case (state_q)
            IDLE: begin
                if (take) begin
                    if (grant == GRANT_B) begin
                        state_d = SERVE_B;
                        addr_d  = mem_address_b;
                        wdata_d = mem_wdata_b;
                        write_d = mem_write_b;
                        be_d    = mem_write_b ? mem_byte_en_b : ByteEnAll;
                    end else begin
                        state_d = SERVE_A;
                        addr_d  = mem_address_a;
                        wdata_d = '0;
                        write_d = 1'b0;
                        be_d    = ByteEnAll;
                    end
                end
            end
            SERVE_A, SERVE_B: begin
                if (pmem_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Responses are masked while rst_n is low so an abandoned transaction never pulses.
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        pmem_byte_en = '0;
        mem_resp_a   = 1'b0;
        mem_resp_b   = 1'b0;
        mem_rdata_a  = '0;
        mem_rdata_b  = '0;
        unique case (state_q)
            SERVE_A: begin
                pmem_read    = 1'b1;
                pmem_address = addr_q;
                pmem_wdata   = wdata_q;
                pmem_byte_en = be_q;
                mem_resp_a   = pmem_resp & req_a & rst_n;
                if (mem_resp_a) begin
                    mem_rdata_a = pmem_rdata;
                end
            end
            SERVE_B: begin
                pmem_read    = ~write_q;
                pmem_write   = write_q;
                pmem_address = addr_q;
                pmem_wdata   = wdata_q;
                pmem_byte_en = be_q;
                mem_resp_b   = pmem_resp & req_b & rst_n;
                if (mem_resp_b) begin
                    mem_rdata_b = pmem_rdata;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a reference model predicts physical transactions
// and responses; an independent monitor compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        mem_read_a;
    logic [15:0] mem_address_a;
    logic [15:0] mem_rdata_a;
    logic        mem_resp_a;
    logic        mem_read_b;
    logic        mem_write_b;
    logic [15:0] mem_address_b;
    logic [15:0] mem_wdata_b;
    logic [1:0]  mem_byte_en_b;
    logic [15:0] mem_rdata_b;
    logic        mem_resp_b;
    logic        pmem_read;
    logic        pmem_write;
    logic [15:0] pmem_address;
    logic [15:0] pmem_wdata;
    logic [1:0]  pmem_byte_en;
    logic [15:0] pmem_rdata;
    logic        pmem_resp;

    mem_arbiter #(
        .ADDR_W (16),
        .DATA_W (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_read_a    (mem_read_a),
        .mem_address_a (mem_address_a),
        .mem_rdata_a   (mem_rdata_a),
        .mem_resp_a    (mem_resp_a),
        .mem_read_b    (mem_read_b),
        .mem_write_b   (mem_write_b),
        .mem_address_b (mem_address_b),
        .mem_wdata_b   (mem_wdata_b),
        .mem_byte_en_b (mem_byte_en_b),
        .mem_rdata_b   (mem_rdata_b),
        .mem_resp_b    (mem_resp_b),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_address  (pmem_address),
        .pmem_wdata    (pmem_wdata),
        .pmem_byte_en  (pmem_byte_en),
        .pmem_rdata    (pmem_rdata),
        .pmem_resp     (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          write;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
    } pm_t;

    pm_t         exp_pm[$];
    logic [15:0] exp_ra[$];
    logic [15:0] exp_rb[$];
    logic [15:0] ref_mem[logic [15:0]];
    logic [15:0] slv_mem[logic [15:0]];
    int          n_cmp     = 0;
    int          n_err     = 0;
    int          force_lat = -1;
    bit          mon_en    = 0;
`ifdef MEM_ARB_RR_EN
    bit          last_b    = 0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : (a ^ 16'h5A3C);
    endfunction

    function automatic logic [15:0] slv_rd(input logic [15:0] a);
        return slv_mem.exists(a) ? slv_mem[a] : (a ^ 16'h5A3C);
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] n,
                                          input logic [1:0] be);
        return {be[1] ? n[15:8] : o[15:8], be[0] ? n[7:0] : o[7:0]};
    endfunction

    // One granted transaction in predicted service order.
    task automatic model_serve(input bit port_b, input bit wr, input logic [15:0] a,
                               input logic [15:0] wd, input logic [1:0] be,
                               input bit completes, input bit want_resp);
        pm_t         e;
        logic [15:0] old;
        old     = ref_rd(a);
        e.write = wr;
        e.addr  = a;
        e.wdata = wd;
        e.be    = wr ? be : 2'b11;
        exp_pm.push_back(e);
        if (wr && completes) ref_mem[a] = merge(old, wd, be);
        if (want_resp) begin
            if (port_b) exp_rb.push_back(old);
            else exp_ra.push_back(old);
        end
`ifdef MEM_ARB_RR_EN
        last_b = port_b;
`endif
    endtask

    // Physical memory: random (or forced) latency, spurious pmem_resp while idle.
    initial begin
        int cnt;
        bit busy;
        cnt        = 0;
        busy       = 0;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            pmem_resp  = 1'b0;
            pmem_rdata = '0;
            if (pmem_read === 1'b1 || pmem_write === 1'b1) begin
                if (!busy) begin
                    busy = 1;
                    cnt  = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
                end
                if (cnt == 0) begin
                    pmem_rdata = slv_rd(pmem_address);
                    pmem_resp  = 1'b1;
                    busy       = 0;
                    if (pmem_write) slv_mem[pmem_address] = merge(pmem_rdata, pmem_wdata, pmem_byte_en);
                end else begin
                    cnt--;
                end
            end else begin
                busy = 0;
                if ($urandom_range(0, 7) == 0) begin
                    pmem_resp  = 1'b1;
                    pmem_rdata = 16'($urandom);
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT starts a transaction or pulses a response.
    initial begin
        bit  prev;
        bit  strobe;
        pm_t e;
        prev = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                strobe = (pmem_read === 1'b1) || (pmem_write === 1'b1);
                if (strobe && !prev) begin
                    if (exp_pm.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL pmem_unexpected: got addr %h want no transaction", pmem_address);
                    end else begin
                        e = exp_pm.pop_front();
                        check("pmem_write", pmem_write, e.write);
                        check("pmem_read", pmem_read, !e.write);
                        check("pmem_address", pmem_address, e.addr);
                        check("pmem_byte_en", pmem_byte_en, e.be);
                        if (e.write) check("pmem_wdata", pmem_wdata, e.wdata);
                    end
                end
                prev = strobe;
                if (mem_resp_a && mem_resp_b) check("resp_exclusive", 2'b11, 2'b01);
                if (mem_resp_a === 1'b1) begin
                    if (exp_ra.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL resp_a_unexpected: got pulse want none");
                    end else begin
                        check("rdata_a", mem_rdata_a, exp_ra.pop_front());
                    end
                end else begin
                    check("rdata_a_quiet", mem_rdata_a, 16'h0);
                end
                if (mem_resp_b === 1'b1) begin
                    if (exp_rb.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL resp_b_unexpected: got pulse want none");
                    end else begin
                        check("rdata_b", mem_rdata_b, exp_rb.pop_front());
                    end
                end else begin
                    check("rdata_b_quiet", mem_rdata_b, 16'h0);
                end
            end
        end
    end

    // Holds requests until their response, dropping each one the cycle after its pulse.
    task automatic wait_resps(input bit wa, input bit wb, input bit chk_lat);
        bit done_a;
        bit done_b;
        done_a = !wa;
        done_b = !wb;
        for (int k = 0; k < 80 && !(done_a && done_b); k++) begin
            @(negedge clk);
            if (chk_lat && k == 0) check("strobe_before_grant", pmem_read | pmem_write, 1'b0);
            if (chk_lat && k == 1) check("strobe_latency", pmem_read | pmem_write, 1'b1);
            if (mem_resp_a) done_a = 1;
            if (mem_resp_b) done_b = 1;
            @(posedge clk);
            #1;
            if (done_a) mem_read_a = 1'b0;
            if (done_b) begin
                mem_read_b  = 1'b0;
                mem_write_b = 1'b0;
            end
        end
        if (!(done_a && done_b)) begin
            n_cmp++;
            n_err++;
            $display("FAIL resp_timeout: got done_a=%0b done_b=%0b want both", done_a, done_b);
            mem_read_a  = 1'b0;
            mem_read_b  = 1'b0;
            mem_write_b = 1'b0;
        end
    endtask

    task automatic issue(input bit da, input logic [15:0] aa, input bit rb, input bit wb,
                         input logic [15:0] ab, input logic [15:0] wd, input logic [1:0] be);
        bit db;
        bit b_first;
        db      = rb | wb;
        b_first = db;
        if (da && db) begin
`ifdef MEM_ARB_RR_EN
            b_first = !last_b;
`else
            b_first = 1;
`endif
        end
        if (b_first && db) model_serve(1, wb, ab, wd, be, 1, 1);
        if (da) model_serve(0, 0, aa, 16'h0, 2'b11, 1, 1);
        if (!b_first && db) model_serve(1, wb, ab, wd, be, 1, 1);
        mem_read_a    = da;
        mem_address_a = aa;
        mem_read_b    = rb;
        mem_write_b   = wb;
        mem_address_b = ab;
        mem_wdata_b   = wd;
        mem_byte_en_b = be;
        wait_resps(da, db, 1);
    endtask

    task automatic wait_strobe(input bit want, input string name);
        bit seen;
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if ((pmem_read | pmem_write) == want) seen = 1;
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: got no strobe=%0b want strobe=%0b", name, !want, want);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          da;
        bit [1:0]    bk;
        logic [15:0] aa;
        logic [15:0] ab;

        rst_n         = 1'b0;
        mem_read_a    = 1'b1;
        mem_address_a = 16'h3010;
        mem_read_b    = 1'b0;
        mem_write_b   = 1'b0;
        mem_address_b = '0;
        mem_wdata_b   = '0;
        mem_byte_en_b = '0;

        // Reset held two edges with a fetch pending.
        model_serve(0, 0, 16'h3010, 16'h0, 2'b11, 1, 1);
        @(posedge clk);
        #1;
        mon_en = 1;
        @(negedge clk);
        check("reset_pmem_read", pmem_read, 1'b0);
        check("reset_resp_a", mem_resp_a, 1'b0);
        @(posedge clk);
        #1;
        check("reset_pmem_read_2", pmem_read, 1'b0);
        rst_n = 1'b1;
        wait_resps(1, 0, 1);

        // Fetch with three wait cycles.
        ref_mem[16'h3000] = 16'h1234;
        slv_mem[16'h3000] = 16'h1234;
        force_lat = 3;
        issue(1, 16'h3000, 0, 0, 16'h0, 16'h0, 2'b00);
        check("fetch_value_model", ref_rd(16'h3000), 16'h1234);
        force_lat = -1;

        // Conflict, then read+write on B.
        issue(1, 16'h3002, 0, 1, 16'h4000, 16'hBEEF, 2'b01);
        issue(0, 16'h0, 1, 1, 16'h4002, 16'h1357, 2'b10);

        // Fetch dropped mid-service.
        force_lat = 3;
        model_serve(0, 0, 16'h3004, 16'h0, 2'b11, 1, 0);
        mem_read_a    = 1'b1;
        mem_address_a = 16'h3004;
        wait_strobe(1, "drop_strobe_start");
        @(posedge clk);
        #1;
        mem_read_a = 1'b0;
        wait_strobe(0, "drop_strobe_end");
        @(negedge clk);
        check("drop_back_idle", pmem_read | pmem_write, 1'b0);
        @(posedge clk);
        #1;

        // Reset while serving a B write.
        force_lat = 6;
        model_serve(1, 1, 16'h4004, 16'hCAFE, 2'b11, 0, 0);
        mem_write_b   = 1'b1;
        mem_address_b = 16'h4004;
        mem_wdata_b   = 16'hCAFE;
        mem_byte_en_b = 2'b11;
        wait_strobe(1, "rst_strobe_start");
        @(posedge clk);
        #1;
        rst_n       = 1'b0;
        mem_write_b = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_mid_pmem_write", pmem_write, 1'b0);
        check("rst_mid_pmem_read", pmem_read, 1'b0);
        check("rst_mid_resp_b", mem_resp_b, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
`ifdef MEM_ARB_RR_EN
        last_b = 0;
`endif
        force_lat = -1;

        for (int r = 0; r < 60; r++) begin
            da = 1'($urandom_range(0, 1));
            bk = 2'($urandom_range(0, 3));
            if (!da && bk == 2'b00) da = 1;
            aa = 16'h4000 + 16'($urandom_range(0, 7));
            ab = 16'h4000 + 16'($urandom_range(0, 7));
            issue(da, aa, bk[0], bk[1], ab, 16'($urandom), 2'($urandom_range(0, 3)));
        end

        repeat (3) @(posedge clk);
        #1;
        check("pm_queue_drained", exp_pm.size(), 0);
        check("ra_queue_drained", exp_ra.size(), 0);
        check("rb_queue_drained", exp_rb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
